// File: rtl/ipg_tx.sv
// IPG transmit inserter: swaps all-idle control blocks for IPG request (0x1a) or
// response (0x1f) blocks. Optional macro IPG_TX_FAIR_EN alternates priority under contention.
module ipg_tx #(
  parameter int unsigned REQ_FIFO_ADDR_WIDTH = 2,
  parameter int unsigned CNT_WIDTH           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          encoded_tx_data_in,
  input  logic [1:0]           encoded_tx_hdr_in,
  input  logic [55:0]          req_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [55:0]          resp_data,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  output logic [63:0]          encoded_tx_data_out,
  output logic [1:0]           encoded_tx_hdr_out,
  output logic                 ipg_sent,
  output logic                 ipg_sent_type,
  output logic                 collision_err,
  output logic [CNT_WIDTH-1:0] req_sent_cnt,
  output logic [CNT_WIDTH-1:0] resp_sent_cnt
);

  localparam int unsigned AW    = REQ_FIFO_ADDR_WIDTH;
  localparam int unsigned Depth = 2 ** REQ_FIFO_ADDR_WIDTH;

  logic [55:0]          mem_q [Depth];
  logic [55:0]          mem_d [Depth];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [55:0]          resp_reg_q, resp_reg_d;
  logic                 resp_pending_q, resp_pending_d;
  logic [63:0]          data_q, data_d;
  logic [1:0]           hdr_q, hdr_d;
  logic                 sent_q, sent_d, type_q, type_d, coll_q, coll_d;
  logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
`ifdef IPG_TX_FAIR_EN
  logic                 last_served_q, last_served_d;  // 0 = request, 1 = response
`endif

  logic fifo_full, fifo_empty, idle_slot, collision, serve_resp, serve_req, push;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    idle_slot  = (encoded_tx_hdr_in == 2'b01) && (encoded_tx_data_in == 64'h1e);
    collision  = (encoded_tx_hdr_in == 2'b01) &&
                 ((encoded_tx_data_in[7:0] == 8'h1a) || (encoded_tx_data_in[7:0] == 8'h1f));

`ifdef IPG_TX_FAIR_EN
    if (resp_pending_q && !fifo_empty) begin
      serve_resp = idle_slot && !last_served_q;
    end else begin
      serve_resp = idle_slot && resp_pending_q;
    end
`else
    serve_resp = idle_slot && resp_pending_q;
`endif
    serve_req = idle_slot && !fifo_empty && !serve_resp;
    // Ready comes from registers only, so a full FIFO refuses a push even while popping.
    push      = req_valid && !fifo_full;
  end

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    resp_reg_d     = resp_reg_q;
    resp_pending_d = resp_pending_q;
    req_cnt_d      = req_cnt_q;
    resp_cnt_d     = resp_cnt_q;
    hdr_d          = encoded_tx_hdr_in;
    data_d         = encoded_tx_data_in;
    sent_d         = 1'b0;
    type_d         = 1'b0;
    coll_d         = collision;
`ifdef IPG_TX_FAIR_EN
    last_served_d  = last_served_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = req_data;
      wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
    end

    if (serve_resp) begin
      hdr_d          = 2'b01;
      data_d         = {resp_reg_q, 8'h1f};
      sent_d         = 1'b1;
      type_d         = 1'b1;
      resp_pending_d = 1'b0;
      resp_cnt_d     = resp_cnt_q + CNT_WIDTH'(1);
`ifdef IPG_TX_FAIR_EN
      last_served_d  = 1'b1;
`endif
    end else if (serve_req) begin
      hdr_d          = 2'b01;
      data_d         = {mem_q[rd_ptr_q[AW-1:0]], 8'h1a};
      sent_d         = 1'b1;
      rd_ptr_d       = rd_ptr_q + (AW + 1)'(1);
      req_cnt_d      = req_cnt_q + CNT_WIDTH'(1);
`ifdef IPG_TX_FAIR_EN
      last_served_d  = 1'b0;
`endif
    end

    // Load only when empty, so it can never coincide with consumption.
    if (resp_valid && !resp_pending_q) begin
      resp_reg_d     = resp_data;
      resp_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      resp_reg_q     <= '0;
      resp_pending_q <= 1'b0;
      hdr_q          <= 2'b01;
      data_q         <= 64'h1e;
      sent_q         <= 1'b0;
      type_q         <= 1'b0;
      coll_q         <= 1'b0;
      req_cnt_q      <= '0;
      resp_cnt_q     <= '0;
`ifdef IPG_TX_FAIR_EN
      last_served_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      resp_reg_q     <= resp_reg_d;
      resp_pending_q <= resp_pending_d;
      hdr_q          <= hdr_d;
      data_q         <= data_d;
      sent_q         <= sent_d;
      type_q         <= type_d;
      coll_q         <= coll_d;
      req_cnt_q      <= req_cnt_d;
      resp_cnt_q     <= resp_cnt_d;
`ifdef IPG_TX_FAIR_EN
      last_served_q  <= last_served_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req_ready           = !fifo_full;
  assign resp_ready          = !resp_pending_q;
  assign encoded_tx_data_out = data_q;
  assign encoded_tx_hdr_out  = hdr_q;
  assign ipg_sent            = sent_q;
  assign ipg_sent_type       = type_q;
  assign collision_err       = coll_q;
  assign req_sent_cnt        = req_cnt_q;
  assign resp_sent_cnt       = resp_cnt_q;

endmodule

// File: tb/tb_ipg_tx.sv
// Self-checking bench for ipg_tx: directed vector table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_ipg_tx;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din;
  logic [1:0]  hin;
  logic [55:0] req_data, resp_data;
  logic        req_valid, resp_valid, req_ready, resp_ready;
  logic [63:0] dout;
  logic [1:0]  hout;
  logic        ipg_sent, ipg_sent_type, collision_err;
  logic [31:0] req_sent_cnt, resp_sent_cnt;

  ipg_tx #(.REQ_FIFO_ADDR_WIDTH(2), .CNT_WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .encoded_tx_data_in  (din),
    .encoded_tx_hdr_in   (hin),
    .req_data            (req_data),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .resp_data           (resp_data),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .encoded_tx_data_out (dout),
    .encoded_tx_hdr_out  (hout),
    .ipg_sent            (ipg_sent),
    .ipg_sent_type       (ipg_sent_type),
    .collision_err       (collision_err),
    .req_sent_cnt        (req_sent_cnt),
    .resp_sent_cnt       (resp_sent_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [55:0] m_q[$];
  logic        m_pend;
  logic [55:0] m_resp;
  logic [31:0] m_req_cnt, m_resp_cnt;
  logic        m_last;
  logic        m_known = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance one clock with current inputs and compare every output to the model.
  task automatic step();
    logic        idle, coll, do_resp, do_req, push, load;
    logic [1:0]  e_hdr;
    logic [63:0] e_data;
    logic        e_sent, e_type;
    if (m_known) begin
      check("req_ready", {63'd0, req_ready}, {63'd0, m_q.size() < Depth});
      check("resp_ready", {63'd0, resp_ready}, {63'd0, !m_pend});
    end
    idle = (hin == 2'b01) && (din == 64'h1e);
    coll = (hin == 2'b01) && (din[7:0] == 8'h1a || din[7:0] == 8'h1f);
    push = req_valid && (m_q.size() < Depth);
    load = resp_valid && !m_pend;
    do_resp = idle && m_pend;
    do_req  = idle && !m_pend && m_q.size() > 0;
`ifdef IPG_TX_FAIR_EN
    if (idle && m_pend && m_q.size() > 0) begin
      do_resp = (m_last == 1'b0);
      do_req  = !do_resp;
    end
`endif
    e_hdr = hin; e_data = din; e_sent = 1'b0; e_type = 1'b0;
    if (rst) begin
      m_q.delete(); m_pend = 1'b0; m_req_cnt = 0; m_resp_cnt = 0; m_last = 1'b0;
      e_hdr = 2'b01; e_data = 64'h1e; coll = 1'b0; m_known = 1'b1;
    end else begin
      if (do_resp) begin
        e_hdr = 2'b01; e_data = {m_resp, 8'h1f}; e_sent = 1'b1; e_type = 1'b1;
        m_pend = 1'b0; m_resp_cnt++; m_last = 1'b1;
      end else if (do_req) begin
        e_hdr = 2'b01; e_data = {m_q.pop_front(), 8'h1a}; e_sent = 1'b1;
        m_req_cnt++; m_last = 1'b0;
      end
      if (push) m_q.push_back(req_data);
      if (load) begin m_pend = 1'b1; m_resp = resp_data; end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      check("hdr_out", {62'd0, hout}, {62'd0, e_hdr});
      check("data_out", dout, e_data);
      check("ipg_sent", {63'd0, ipg_sent}, {63'd0, e_sent});
      if (e_sent) check("ipg_sent_type", {63'd0, ipg_sent_type}, {63'd0, e_type});
      check("collision_err", {63'd0, collision_err}, {63'd0, coll});
      check("req_sent_cnt", {32'd0, req_sent_cnt}, {32'd0, m_req_cnt});
      check("resp_sent_cnt", {32'd0, resp_sent_cnt}, {32'd0, m_resp_cnt});
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] h, input logic [63:0] d,
                       input logic rv, input logic [55:0] rdat,
                       input logic pv, input logic [55:0] pdat);
    rst = r; hin = h; din = d;
    req_valid = rv; req_data = rdat; resp_valid = pv; resp_data = pdat;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        rv;
    logic [55:0] rdat;
    logic        pv;
    logic [55:0] pdat;
    logic [1:0]  e_hdr;
    logic [63:0] e_data;
    logic        e_sent;
    logic        e_coll;
  } vec_t;

  localparam logic [63:0] Idle = 64'h1e;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0, 2'b01, Idle, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0, 2'b01, Idle, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b10, 64'hdeadbeef00000001, 1'b1, 56'h11223344556677, 1'b0, 56'h0,
                 2'b10, 64'hdeadbeef00000001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b10, 64'h0123456789abcdef, 1'b0, 56'h0, 1'b0, 56'h0,
                 2'b10, 64'h0123456789abcdef, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 64'h000000000000001e, 1'b0, 56'h0, 1'b0, 56'h0,
                 2'b10, 64'h000000000000001e, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0,
                 2'b01, 64'h112233445566771a, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b1, 56'hAAAA, 2'b01, Idle, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 64'h123456789abcde1a, 1'b0, 56'h0, 1'b0, 56'h0,
                 2'b01, 64'h123456789abcde1a, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'b01, Idle, 1'b1, 56'h5555, 1'b0, 56'h0,
                 2'b01, 64'h0000000000AAAA1f, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0,
                 2'b01, 64'h000000000055551a, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0, 2'b01, Idle, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].hdr, vecs[i].data, vecs[i].rv, vecs[i].rdat,
            vecs[i].pv, vecs[i].pdat);
      step();
      check($sformatf("vec%0d_hdr", i), {62'd0, hout}, {62'd0, vecs[i].e_hdr});
      check($sformatf("vec%0d_data", i), dout, vecs[i].e_data);
      check($sformatf("vec%0d_sent", i), {63'd0, ipg_sent}, {63'd0, vecs[i].e_sent});
      check($sformatf("vec%0d_coll", i), {63'd0, collision_err}, {63'd0, vecs[i].e_coll});
    end

    // Fill the FIFO during data blocks; the fifth offer must be refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b10, 64'(i), 1'b1, 56'h100 + 56'(i), 1'b0, 56'h0);
      step();
    end
    check("full_req_ready", {63'd0, req_ready}, 64'd0);
    // Offer while full and popping: refused, ready rises the following cycle.
    drive(1'b0, 2'b01, Idle, 1'b1, 56'hBAD, 1'b0, 56'h0);
    step();
    check("drain0", dout, {56'h100, 8'h1a});
    check("ready_after_pop", {63'd0, req_ready}, 64'd1);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0);
      step();
      if (i < 4) check($sformatf("drain%0d", i), dout, {56'h100 + 56'(i), 8'h1a});
    end
    check("no_bad_entry", dout, Idle);

    // Repeated contention between a response and queued requests.
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 2'b10, 64'h0, 1'b1, 56'h5550 + 56'(r), 1'b1, 56'hAAA0 + 56'(r));
      step();
      drive(1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0);
      step();
    end

    // Collision while a response is pending, then reset with work queued.
    drive(1'b0, 2'b10, 64'h0, 1'b1, 56'h77, 1'b1, 56'h99);
    step();
    drive(1'b0, 2'b10, 64'h1, 1'b1, 56'h78, 1'b0, 56'h0);
    step();
    drive(1'b0, 2'b01, 64'h00000000000abc1f, 1'b0, 56'h0, 1'b0, 56'h0);
    step();
    check("coll_resp_held", {63'd0, resp_ready}, 64'd0);
    drive(1'b1, 2'b10, 64'h5, 1'b0, 56'h0, 1'b0, 56'h0);
    step();
    check("rst_data", dout, Idle);
    check("rst_cnt", {32'd0, req_sent_cnt}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b01, Idle, 1'b0, 56'h0, 1'b0, 56'h0);
      step();
      check("post_rst_idle", dout, Idle);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [63:0] d;
      logic [1:0]  h;
      int          kind;
      kind = int'($urandom_range(0, 9));
      d = {$urandom(), $urandom()};
      if (kind < 5) begin
        h = 2'b01; d = Idle;
      end else if (kind < 7) begin
        h = 2'($urandom_range(0, 3));
      end else if (kind < 8) begin
        h = 2'b01; d[7:0] = 8'h78;
      end else if (kind < 9) begin
        h = 2'b01; d[7:0] = ($urandom_range(0, 1) != 0) ? 8'h1a : 8'h1f;
      end else begin
        h = 2'b01; d = 64'h1e | (64'd1 << $urandom_range(8, 63));
      end
      drive(($urandom_range(0, 99) == 0), h, d,
            ($urandom_range(0, 2) == 0), 56'({$urandom(), $urandom()}),
            ($urandom_range(0, 3) == 0), 56'({$urandom(), $urandom()}));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
